// File: rtl/dcache_pkg.sv
// Shared address layout, SRAM tag layout and controller state encoding for the
// 2-way, 16-set, 256-bit-line data cache.
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 256;
  localparam int TAG_W      = 23;
  localparam int INDEX_W    = 4;
  localparam int WORD_SEL_W = 3;
  localparam int TAG_LSB    = 9;
  localparam int INDEX_LSB  = 5;
  localparam int WORD_LSB   = 2;
  localparam int LINE_OFF_W = 5;

  localparam int SRAM_TAG_W = 25;
  localparam int VALID_BIT  = 24;
  localparam int DIRTY_BIT  = 23;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_READMISS,
    S_READMISSOK
  } state_t;

  function automatic logic [SRAM_TAG_W-1:0] valid_tag(input logic dirty,
                                                      input logic [TAG_W-1:0] tag);
    return {1'b1, dirty, tag};
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [INDEX_W-1:0] index);
    return {tag, index, {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU, tag/data SRAM and main-memory signals of the data-cache controller.
interface dcache_if;
  import dcache_pkg::*;

  logic                  cpu_req_i;
  logic                  cpu_wr_i;
  logic [ADDR_W-1:0]     cpu_addr_i;
  logic [WORD_W-1:0]     cpu_data_i;
  logic [WORD_W-1:0]     cpu_data_o;
  logic                  cpu_stall_o;

  logic [INDEX_W-1:0]    sram_addr_o;
  logic [SRAM_TAG_W-1:0] sram_tag_o;
  logic [LINE_W-1:0]     sram_data_o;
  logic                  sram_enable_o;
  logic                  sram_write_o;
  logic [SRAM_TAG_W-1:0] sram_tag_i;
  logic [LINE_W-1:0]     sram_data_i;
  logic                  sram_hit_i;

  logic                  mem_enable_o;
  logic                  mem_write_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [LINE_W-1:0]     mem_data_o;
  logic [LINE_W-1:0]     mem_data_i;
  logic                  mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_data_i,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o,
    output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport slave (
    output cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_data_i,
    output sram_tag_i, sram_data_i, sram_hit_i,
    output mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dcache_word_mux.sv
// Word select out of a cache line for loads, and single-word merge into a line
// for stores.
module dcache_word_mux
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0]     line,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata,
  output logic [LINE_W-1:0]     merged
);

  logic [7:0] bit_base;

  assign bit_base = {word_sel, 5'b0};
  assign rdata    = line[bit_base +: WORD_W];

  always_comb begin
    merged                    = line;
    merged[bit_base +: WORD_W] = wdata;
  end

endmodule

// File: rtl/dcache_controller.sv
// Request-side data-cache controller: hit service, write-back/write-allocate
// miss handling, SRAM refill and CPU stall generation.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int MEM_LAT_MAX = 0
) (
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.master bus
);

  if (MEM_LAT_MAX < 0) begin : g_bad_lat
    $error("MEM_LAT_MAX must be non-negative");
  end

  state_t                state_q, state_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]     mem_data_q, mem_data_d;
  logic [LINE_W-1:0]     refill_q, refill_d;

  logic [TAG_W-1:0]      cpu_tag;
  logic [INDEX_W-1:0]    cpu_index;
  logic [WORD_SEL_W-1:0] cpu_word;
  logic [LINE_W-1:0]     merged_line;
  logic                  unused_byte_off;

  assign cpu_tag         = bus.cpu_addr_i[TAG_LSB +: TAG_W];
  assign cpu_index       = bus.cpu_addr_i[INDEX_LSB +: INDEX_W];
  assign cpu_word        = bus.cpu_addr_i[WORD_LSB +: WORD_SEL_W];
  assign unused_byte_off = ^bus.cpu_addr_i[WORD_LSB-1:0];

  dcache_word_mux u_word_mux (
    .line     (bus.sram_data_i),
    .word_sel (cpu_word),
    .wdata    (bus.cpu_data_i),
    .rdata    (bus.cpu_data_o),
    .merged   (merged_line)
  );

  assign bus.sram_addr_o  = cpu_index;
  assign bus.cpu_stall_o  = bus.cpu_req_i & ((state_q != S_IDLE) | ~bus.sram_hit_i);
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      refill_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      refill_q     <= refill_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    mem_enable_d      = mem_enable_q;
    mem_write_d       = mem_write_q;
    mem_addr_d        = mem_addr_q;
    mem_data_d        = mem_data_q;
    refill_d          = refill_q;
    bus.sram_enable_o = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.sram_tag_o    = valid_tag(1'b0, cpu_tag);
    bus.sram_data_o   = refill_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req_i) begin
          if (bus.sram_hit_i) begin
            // a load hit still enables the SRAM so it can refresh LRU
            bus.sram_enable_o = 1'b1;
            if (bus.cpu_wr_i) begin
              bus.sram_write_o = 1'b1;
              bus.sram_tag_o   = valid_tag(1'b1, cpu_tag);
              bus.sram_data_o  = merged_line;
            end
          end else begin
            state_d = S_MISS;
          end
        end
      end

      S_MISS: begin
        mem_enable_d = 1'b1;
        if (bus.sram_tag_i[VALID_BIT] && bus.sram_tag_i[DIRTY_BIT]) begin
          mem_write_d = 1'b1;
          mem_addr_d  = line_addr(bus.sram_tag_i[TAG_W-1:0], cpu_index);
          mem_data_d  = bus.sram_data_i;
          state_d     = S_WRITEBACK;
        end else begin
          mem_write_d = 1'b0;
          mem_addr_d  = line_addr(cpu_tag, cpu_index);
          state_d     = S_READMISS;
        end
      end

      S_WRITEBACK: begin
        if (bus.mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = line_addr(cpu_tag, cpu_index);
          state_d     = S_READMISS;
        end
      end

      S_READMISS: begin
        if (bus.mem_ack_i) begin
          refill_d     = bus.mem_data_i;
          mem_enable_d = 1'b0;
          state_d      = S_READMISSOK;
        end
      end

      S_READMISSOK: begin
        // line installed clean; a pending store dirties it on the re-hit
        bus.sram_enable_o = 1'b1;
        bus.sram_write_o  = 1'b1;
        state_d           = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 2-way LRU tag/data SRAM model and
// a latency-programmable memory responder.
module tb_dcache_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus();

  dcache_controller #(.MEM_LAT_MAX(64)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [255:0] make_line(input logic [31:0] seed);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = seed + 32'(i);
    return l;
  endfunction

  // two-way SRAM model, LRU bit names the way to evict
  logic [24:0]  tg [2][16];
  logic [255:0] dt [2][16];
  logic         lru [16];
  logic         hit0, hit1, way;
  logic [3:0]   sidx;
  logic [22:0]  stag;

  always_comb begin
    sidx = bus.sram_addr_o;
    stag = bus.cpu_addr_i[31:9];
    hit0 = tg[0][sidx][24] && (tg[0][sidx][22:0] == stag);
    hit1 = tg[1][sidx][24] && (tg[1][sidx][22:0] == stag);
    way  = hit0 ? 1'b0 : (hit1 ? 1'b1 : lru[sidx]);
    bus.sram_hit_i  = hit0 | hit1;
    bus.sram_tag_i  = tg[way][sidx];
    bus.sram_data_i = dt[way][sidx];
  end

  logic         pl_req = 1'b0;
  logic         pl_way = 1'b0;
  logic [3:0]   pl_idx = '0;
  logic [24:0]  pl_tag = '0;
  logic [255:0] pl_data = '0;
  logic         pl_lru = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 16; s++) begin
          tg[w][s] <= '0;
          dt[w][s] <= '0;
        end
      for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
    end else if (pl_req) begin
      tg[pl_way][pl_idx] <= pl_tag;
      dt[pl_way][pl_idx] <= pl_data;
      lru[pl_idx]        <= pl_lru;
    end else if (bus.sram_enable_o) begin
      if (bus.sram_write_o) begin
        tg[way][sidx] <= bus.sram_tag_o;
        dt[way][sidx] <= bus.sram_data_o;
      end
      lru[sidx] <= ~way;
    end
  end

  // memory responder: ack after lat full enable cycles, logs each transfer
  logic         ack_auto = 1'b0;
  logic         ack_man  = 1'b0;
  logic         mem_auto = 1'b1;
  int           lat_wb = 0, lat_rd = 0, wcnt = 0;
  logic [255:0] refill_line = '0;
  int           rd_count = 0, wb_count = 0;
  logic [31:0]  rd_addr_log = '0, wb_addr_log = '0;
  logic [255:0] wb_data_log = '0;

  assign bus.mem_ack_i  = ack_auto | ack_man;
  assign bus.mem_data_i = refill_line;

  initial forever begin
    @(negedge clk);
    if (rst || !mem_auto || !bus.mem_enable_o) begin
      ack_auto = 1'b0;
      wcnt     = 0;
    end else if (wcnt == (bus.mem_write_o ? lat_wb : lat_rd)) begin
      ack_auto = 1'b1;
      wcnt     = 0;
      if (bus.mem_write_o) begin
        wb_count++;
        wb_addr_log = bus.mem_addr_o;
        wb_data_log = bus.mem_data_o;
      end else begin
        rd_count++;
        rd_addr_log = bus.mem_addr_o;
      end
    end else begin
      ack_auto = 1'b0;
      wcnt++;
    end
  end

  // starts at posedge+1, returns at the first negedge with stall low
  task automatic run_req(input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, output int len);
    bus.cpu_addr_i = addr;
    bus.cpu_wr_i   = wr;
    bus.cpu_data_i = wdata;
    bus.cpu_req_i  = 1'b1;
    len = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) return;
      len++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_mis++;
    $display("FAIL stall_timeout: still stalled after %0d cycles, required release", len);
  endtask

  task automatic release_req();
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
    bus.cpu_wr_i  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (bus.mem_enable_o !== 1'b0) begin n_mis++; $display("FAIL rst_mem_enable: got %b, expected 0", bus.mem_enable_o); end
    n_cmp++; if (bus.mem_write_o !== 1'b0) begin n_mis++; $display("FAIL rst_mem_write: got %b, expected 0", bus.mem_write_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_mis++; $display("FAIL rst_mem_addr: got %h, expected 0", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_data_o !== 256'h0) begin n_mis++; $display("FAIL rst_mem_data: got %h, expected 0", bus.mem_data_o); end
    n_cmp++; if (bus.cpu_stall_o !== 1'b0) begin n_mis++; $display("FAIL rst_stall_idle: got %b, expected 0", bus.cpu_stall_o); end
    bus.cpu_addr_i = 32'h0000_0124;
    bus.cpu_req_i  = 1'b1;
    #1;
    n_cmp++; if (bus.cpu_stall_o !== 1'b1) begin n_mis++; $display("FAIL rst_stall_miss: got %b, expected 1", bus.cpu_stall_o); end
    n_cmp++; if (bus.sram_addr_o !== 4'h9) begin n_mis++; $display("FAIL rst_sram_addr: got %h, expected 9", bus.sram_addr_o); end
    n_cmp++; if (bus.sram_enable_o !== 1'b0) begin n_mis++; $display("FAIL rst_sram_enable: got %b, expected 0", bus.sram_enable_o); end
    bus.cpu_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [255:0] l1, l_st;

  task automatic test_cold_load();
    int len, rd0, wb0;
    l1 = make_line(32'hA000_0000);
    l1[63:32] = 32'hDEAD_BEEF;
    refill_line = l1;
    lat_rd = 0;
    rd0 = rd_count;
    wb0 = wb_count;
    run_req(32'h0000_0124, 1'b0, 32'h0, len);
    n_cmp++; if (len !== 4) begin n_mis++; $display("FAIL cold_stall: got %0d, expected 4", len); end
    n_cmp++; if (rd_count !== rd0 + 1) begin n_mis++; $display("FAIL cold_reads: got %0d, expected %0d", rd_count, rd0 + 1); end
    n_cmp++; if (rd_addr_log !== 32'h0000_0120) begin n_mis++; $display("FAIL cold_rd_addr: got %h, expected 00000120", rd_addr_log); end
    n_cmp++; if (wb_count !== wb0) begin n_mis++; $display("FAIL cold_no_wb: got %0d, expected %0d", wb_count, wb0); end
    n_cmp++; if (bus.cpu_data_o !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL cold_data: got %h, expected deadbeef", bus.cpu_data_o); end
    release_req();
  endtask

  task automatic test_store_hit();
    int len;
    l_st = l1;
    l_st[63:32] = 32'h1234_5678;
    run_req(32'h0000_0124, 1'b1, 32'h1234_5678, len);
    n_cmp++; if (len !== 0) begin n_mis++; $display("FAIL st_stall: got %0d, expected 0", len); end
    n_cmp++; if ({bus.sram_enable_o, bus.sram_write_o} !== 2'b11) begin n_mis++; $display("FAIL st_en_wr: got %b, expected 11", {bus.sram_enable_o, bus.sram_write_o}); end
    n_cmp++; if (bus.sram_tag_o !== 25'h180_0000) begin n_mis++; $display("FAIL st_tag: got %h, expected 1800000", bus.sram_tag_o); end
    n_cmp++; if (bus.sram_data_o !== l_st) begin n_mis++; $display("FAIL st_data: got %h, expected %h", bus.sram_data_o, l_st); end
    release_req();
  endtask

  task automatic test_clean_latency();
    logic [31:0] addrs [3] = '{32'h0000_002C, 32'h0000_0044, 32'h0000_007C};
    logic [31:0] lines [3] = '{32'h0000_0020, 32'h0000_0040, 32'h0000_0060};
    logic [31:0] words [3] = '{32'hC000_0003, 32'hC000_0101, 32'hC000_0207};
    int          lats  [3] = '{0, 1, 10};
    int          exps  [3] = '{4, 5, 14};
    int          len;
    for (int k = 0; k < 3; k++) begin
      lat_rd = lats[k];
      refill_line = make_line(32'hC000_0000 + 32'(k * 256));
      run_req(addrs[k], 1'b0, 32'h0, len);
      n_cmp++; if (len !== exps[k]) begin n_mis++; $display("FAIL lat%0d_stall: got %0d, expected %0d", lats[k], len, exps[k]); end
      n_cmp++; if (rd_addr_log !== lines[k]) begin n_mis++; $display("FAIL lat%0d_rd_addr: got %h, expected %h", lats[k], rd_addr_log, lines[k]); end
      n_cmp++; if (bus.cpu_data_o !== words[k]) begin n_mis++; $display("FAIL lat%0d_data: got %h, expected %h", lats[k], bus.cpu_data_o, words[k]); end
      release_req();
    end
  endtask

  task automatic test_dirty_writeback();
    int len, wb0;
    lat_rd = 0;
    refill_line = make_line(32'hB000_0000);
    run_req(32'h0000_2124, 1'b1, 32'hCAFE_F00D, len);
    n_cmp++; if (len !== 4) begin n_mis++; $display("FAIL fill2_stall: got %0d, expected 4", len); end
    n_cmp++; if (rd_addr_log !== 32'h0000_2120) begin n_mis++; $display("FAIL fill2_rd_addr: got %h, expected 00002120", rd_addr_log); end
    n_cmp++; if (bus.sram_tag_o !== 25'h180_0010) begin n_mis++; $display("FAIL fill2_tag: got %h, expected 1800010", bus.sram_tag_o); end
    release_req();
    lat_wb = 2;
    lat_rd = 1;
    refill_line = make_line(32'hE000_0000);
    wb0 = wb_count;
    run_req(32'h0000_4124, 1'b0, 32'h0, len);
    n_cmp++; if (len !== 8) begin n_mis++; $display("FAIL dirty_stall: got %0d, expected 8", len); end
    n_cmp++; if (wb_count !== wb0 + 1) begin n_mis++; $display("FAIL dirty_wb_count: got %0d, expected %0d", wb_count, wb0 + 1); end
    n_cmp++; if (wb_addr_log !== 32'h0000_0120) begin n_mis++; $display("FAIL dirty_wb_addr: got %h, expected 00000120", wb_addr_log); end
    n_cmp++; if (wb_data_log !== l_st) begin n_mis++; $display("FAIL dirty_wb_data: got %h, expected %h", wb_data_log, l_st); end
    n_cmp++; if (rd_addr_log !== 32'h0000_4120) begin n_mis++; $display("FAIL dirty_rd_addr: got %h, expected 00004120", rd_addr_log); end
    n_cmp++; if (bus.cpu_data_o !== 32'hE000_0001) begin n_mis++; $display("FAIL dirty_data: got %h, expected e0000001", bus.cpu_data_o); end
    release_req();
  endtask

  task automatic test_drop_req();
    int   len;
    logic saw_wb, saw_ok;
    pl_way  = 1'b0;
    pl_idx  = 4'h5;
    pl_tag  = 25'h180_0007;
    pl_data = make_line(32'h5500_0000);
    pl_lru  = 1'b0;
    pl_req  = 1'b1;
    @(posedge clk);
    #1;
    pl_req = 1'b0;
    lat_wb = 5;
    lat_rd = 2;
    refill_line = make_line(32'h7700_0000);
    bus.cpu_addr_i = 32'h0000_00A8;
    bus.cpu_wr_i   = 1'b0;
    bus.cpu_req_i  = 1'b1;
    saw_wb = 1'b0;
    for (int c = 0; c < 20 && !saw_wb; c++) begin
      @(negedge clk);
      saw_wb = bus.mem_enable_o & bus.mem_write_o;
    end
    n_cmp++; if (saw_wb !== 1'b1) begin n_mis++; $display("FAIL drop_enter_wb: got %b, expected 1", saw_wb); end
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
    saw_ok = 1'b0;
    for (int c = 0; c < 40 && !saw_ok; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.cpu_stall_o !== 1'b0) begin n_mis++; $display("FAIL drop_stall_c%0d: got %b, expected 0", c, bus.cpu_stall_o); end
      saw_ok = bus.sram_enable_o & bus.sram_write_o;
      if (!saw_ok) begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++; if (saw_ok !== 1'b1) begin n_mis++; $display("FAIL drop_refill: got %b, expected 1", saw_ok); end
    n_cmp++; if (wb_addr_log !== 32'h0000_0EA0) begin n_mis++; $display("FAIL drop_wb_addr: got %h, expected 00000ea0", wb_addr_log); end
    n_cmp++; if (wb_data_log !== make_line(32'h5500_0000)) begin n_mis++; $display("FAIL drop_wb_data: got %h, expected victim line", wb_data_log); end
    n_cmp++; if (rd_addr_log !== 32'h0000_00A0) begin n_mis++; $display("FAIL drop_rd_addr: got %h, expected 000000a0", rd_addr_log); end
    @(posedge clk);
    #1;
    run_req(32'h0000_00A8, 1'b0, 32'h0, len);
    n_cmp++; if (len !== 0) begin n_mis++; $display("FAIL drop_rehit_stall: got %0d, expected 0", len); end
    n_cmp++; if (bus.cpu_data_o !== 32'h7700_0002) begin n_mis++; $display("FAIL drop_rehit_data: got %h, expected 77000002", bus.cpu_data_o); end
    release_req();
  endtask

  task automatic test_reset_mid();
    int   len;
    logic saw_rd;
    lat_rd = 20;
    refill_line = make_line(32'h3300_0000);
    bus.cpu_addr_i = 32'h0000_0084;
    bus.cpu_wr_i   = 1'b0;
    bus.cpu_req_i  = 1'b1;
    saw_rd = 1'b0;
    for (int c = 0; c < 10 && !saw_rd; c++) begin
      @(negedge clk);
      saw_rd = bus.mem_enable_o & ~bus.mem_write_o;
    end
    n_cmp++; if (saw_rd !== 1'b1) begin n_mis++; $display("FAIL rmid_enter_rd: got %b, expected 1", saw_rd); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.mem_addr_o !== 32'h0000_0080) begin n_mis++; $display("FAIL rmid_pre_addr: got %h, expected 00000080", bus.mem_addr_o); end
    rst = 1'b1;
    bus.cpu_req_i = 1'b0;
    #1;
    n_cmp++; if (bus.mem_enable_o !== 1'b0) begin n_mis++; $display("FAIL rmid_mem_enable: got %b, expected 0", bus.mem_enable_o); end
    n_cmp++; if (bus.mem_write_o !== 1'b0) begin n_mis++; $display("FAIL rmid_mem_write: got %b, expected 0", bus.mem_write_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_mis++; $display("FAIL rmid_mem_addr: got %h, expected 0", bus.mem_addr_o); end
    n_cmp++; if (bus.mem_data_o !== 256'h0) begin n_mis++; $display("FAIL rmid_mem_data: got %h, expected 0", bus.mem_data_o); end
    n_cmp++; if (bus.cpu_stall_o !== 1'b0) begin n_mis++; $display("FAIL rmid_stall: got %b, expected 0", bus.cpu_stall_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_auto = 1'b0;
    @(negedge clk);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({bus.mem_enable_o, bus.sram_enable_o} !== 2'b00) begin n_mis++; $display("FAIL rmid_ack_ignored_c%0d: got %b, expected 00", c, {bus.mem_enable_o, bus.sram_enable_o}); end
    end
    @(posedge clk);
    #1;
    mem_auto = 1'b1;
    lat_rd = 0;
    run_req(32'h0000_0084, 1'b0, 32'h0, len);
    n_cmp++; if (len !== 4) begin n_mis++; $display("FAIL rmid_retry_stall: got %0d, expected 4", len); end
    n_cmp++; if (rd_addr_log !== 32'h0000_0080) begin n_mis++; $display("FAIL rmid_retry_addr: got %h, expected 00000080", rd_addr_log); end
    n_cmp++; if (bus.cpu_data_o !== 32'h3300_0001) begin n_mis++; $display("FAIL rmid_retry_data: got %h, expected 33000001", bus.cpu_data_o); end
    release_req();
  endtask

  initial begin
    bus.cpu_req_i  = 1'b0;
    bus.cpu_wr_i   = 1'b0;
    bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_clean_latency();
    test_dirty_writeback();
    test_drop_req();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
